// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared types and helpers for the level countdown timer.
//   timer_state_t : timer FSM states
//   bcd_time_t    : M:ST:SU display digits (min, tens, units)
//   sec_to_bcd    : 10-bit seconds -> BCD digits, saturating at MAX_SEC
//   bcd_to_sec    : BCD digits -> 10-bit seconds
package game_timer_pkg;

  localparam int SEC_W   = 10;
  localparam int MAX_SEC = 599;   // 9:59, the largest time the three digits can show

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RUN     = 3'd2,
    ST_HOLD    = 3'd3,
    ST_EXPIRED = 3'd4
  } timer_state_t;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_time_t;

  function automatic bcd_time_t sec_to_bcd(input logic [SEC_W-1:0] sec);
    logic [SEC_W-1:0] s;
    logic [SEC_W-1:0] rem;
    bcd_time_t        t;
    s       = (sec > SEC_W'(MAX_SEC)) ? SEC_W'(MAX_SEC) : sec;
    rem     = s % SEC_W'(60);
    t.min   = 4'(s / SEC_W'(60));
    t.tens  = 4'(rem / SEC_W'(10));
    t.units = 4'(rem % SEC_W'(10));
    return t;
  endfunction

  function automatic logic [SEC_W-1:0] bcd_to_sec(input bcd_time_t t);
    return SEC_W'(t.min) * SEC_W'(60) + SEC_W'(t.tens) * SEC_W'(10) + SEC_W'(t.units);
  endfunction

endpackage

// File: rtl/game_timer_ctrl_sec_prescaler.sv
// sec_prescaler: free-running one-second time base.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   pulse  : registered, high for the one cycle after the count reaches CLK_FREQ_HZ-1
module sec_prescaler #(
  parameter int CLK_FREQ_HZ = 25_000_000
) (
  input  logic clk,
  input  logic resetN,
  output logic pulse
);

  localparam int                CNT_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLK_FREQ_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= (r_cnt == LAST);
      if (r_cnt == LAST) r_cnt <= '0;
      else               r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: per-level countdown timer with BCD HUD digits.
//   clk, resetN          : clock, asynchronous active-low reset
//   game_on, pause       : run enable / level-sensitive freeze
//   level_sel, load      : level (2 -> LVL2, anything else -> LVL1), reload pulse
//   bonus_req/bonus_ack  : bonus-time handshake (ack is a one-cycle grant)
//   one_sec_pulse        : free-running 1 Hz tick
//   timer_ended          : sticky expiry flag, cleared by load
//   time_warning         : armed/running/paused and time <= WARN_SEC
//   min_digit/sec_tens/sec_units : remaining time in BCD
//   running              : state is RUN
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int LVL1_SEC    = 180,
  parameter int LVL2_SEC    = 120,
  parameter int BONUS_SEC   = 30,
  parameter int WARN_SEC    = 30
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       game_on,
  input  logic [1:0] level_sel,
  input  logic       load,
  input  logic       pause,
  input  logic       bonus_req,
  output logic       bonus_ack,
  output logic       one_sec_pulse,
  output logic       timer_ended,
  output logic       time_warning,
  output logic [3:0] min_digit,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running
);

  localparam bcd_time_t LVL1_BCD = sec_to_bcd(SEC_W'(LVL1_SEC));
  localparam bcd_time_t LVL2_BCD = sec_to_bcd(SEC_W'(LVL2_SEC));

  timer_state_t     r_state, w_nxt_state;
  bcd_time_t        r_time, w_nxt_time, w_limit;
  logic             r_ended, w_nxt_ended;
  logic             r_ack, r_warn, r_running, w_nxt_warn;
  logic             w_pulse, w_active, w_grant, w_bonus_on, w_dec, w_expire;
  logic [SEC_W-1:0] w_cur_sec, w_sat_sec;
  logic [SEC_W:0]   w_sum;

  sec_prescaler #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_presc (
    .clk    (clk),
    .resetN (resetN),
    .pulse  (w_pulse)
  );

  assign w_cur_sec = bcd_to_sec(r_time);
  assign w_limit   = (level_sel == 2'd2) ? LVL2_BCD : LVL1_BCD;
  assign w_active  = (r_state == ST_ARMED) || (r_state == ST_RUN) || (r_state == ST_HOLD);

  // A held request sees its own ack and is refused for a cycle, so grants
  // come at most every second cycle. IDLE/EXPIRED still ack, without bonus.
  assign w_grant    = bonus_req & ~r_ack;
  assign w_bonus_on = w_grant & w_active;
  assign w_dec      = (r_state == ST_RUN) & w_pulse;

  // A bonus arriving on the final tick rescues the timer.
  assign w_expire   = w_dec & ~w_bonus_on & (w_cur_sec <= SEC_W'(1));

  // Decrement and bonus combine before saturation; the underflow case
  // (0:01 or 0:00 without bonus) is the expiry path and never uses w_sum.
  assign w_sum     = {1'b0, w_cur_sec}
                   + (w_bonus_on ? (SEC_W+1)'(BONUS_SEC) : '0)
                   - {{SEC_W{1'b0}}, w_dec};
  assign w_sat_sec = (w_sum > (SEC_W+1)'(MAX_SEC)) ? SEC_W'(MAX_SEC) : w_sum[SEC_W-1:0];

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_time  = r_time;
    w_nxt_ended = r_ended;
    if (load) begin
      w_nxt_state = ST_ARMED;
      w_nxt_time  = w_limit;
      w_nxt_ended = 1'b0;
    end else if (w_expire) begin
      w_nxt_state = ST_EXPIRED;
      w_nxt_time  = '0;
      w_nxt_ended = 1'b1;
    end else begin
      case (r_state)
        ST_ARMED: if (game_on) w_nxt_state = ST_RUN;
        ST_RUN: begin
          if (pause)         w_nxt_state = ST_HOLD;
          else if (!game_on) w_nxt_state = ST_ARMED;
        end
        ST_HOLD: begin
          if (!game_on)      w_nxt_state = ST_ARMED;
          else if (!pause)   w_nxt_state = ST_RUN;
        end
        default: ;
      endcase
      if (w_dec || w_bonus_on) w_nxt_time = sec_to_bcd(w_sat_sec);
    end
    // Flags are derived from the next state/time so they line up with the digits.
    w_nxt_warn = ((w_nxt_state == ST_ARMED) || (w_nxt_state == ST_RUN) ||
                  (w_nxt_state == ST_HOLD)) &&
                 (bcd_to_sec(w_nxt_time) <= SEC_W'(WARN_SEC));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= ST_IDLE;
      r_time    <= '0;
      r_ended   <= 1'b0;
      r_ack     <= 1'b0;
      r_warn    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_time    <= w_nxt_time;
      r_ended   <= w_nxt_ended;
      r_ack     <= w_grant;
      r_warn    <= w_nxt_warn;
      r_running <= (w_nxt_state == ST_RUN);
    end
  end

  assign bonus_ack     = r_ack;
  assign one_sec_pulse = w_pulse;
  assign timer_ended   = r_ended;
  assign time_warning  = r_warn;
  assign running       = r_running;
  assign min_digit     = r_time.min;
  assign sec_tens      = r_time.tens;
  assign sec_units     = r_time.units;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl with a 10-cycle second,
// LVL1 = 3:00, LVL2 = 0:45, bonus 30 s, warning at 30 s.
module tb_game_timer_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       game_on = 1'b0, load = 1'b0, pause = 1'b0, bonus_req = 1'b0;
  logic [1:0] level_sel = 2'd0;
  logic       bonus_ack, one_sec_pulse, timer_ended, time_warning, running;
  logic [3:0] min_digit, sec_tens, sec_units;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  game_timer_ctrl #(
    .CLK_FREQ_HZ(10), .LVL1_SEC(180), .LVL2_SEC(45), .BONUS_SEC(30), .WARN_SEC(30)
  ) dut (
    .clk(clk), .resetN(resetN), .game_on(game_on), .level_sel(level_sel),
    .load(load), .pause(pause), .bonus_req(bonus_req), .bonus_ack(bonus_ack),
    .one_sec_pulse(one_sec_pulse), .timer_ended(timer_ended),
    .time_warning(time_warning), .min_digit(min_digit), .sec_tens(sec_tens),
    .sec_units(sec_units), .running(running)
  );

  typedef struct {
    string name;
    int    t;      // expected digits as M*100 + tens*10 + units
    logic  run, ended, warn, ack;
  } exp_t;

  typedef struct {
    string      name;
    logic       ld;
    logic [1:0] lvl;
    logic       go, pz, bn, to_pulse;
    int         t;
    logic       run, ended, warn, ack;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[17];

  function automatic int mmss(input int s);
    return (s / 60) * 100 + ((s % 60) / 10) * 10 + (s % 10);
  endfunction

  function automatic int dut_time();
    return int'(min_digit) * 100 + int'(sec_tens) * 10 + int'(sec_units);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for one_sec_pulse", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string name);
    int n = 0;
    while (one_sec_pulse !== 1'b1 && n < 25) begin
      tick();
      n++;
    end
    if (n >= 25) fail_now(name);
  endtask

  // Run through the next pulse cycle (the current one if the pulse is high now).
  task automatic adv_pulse(input string name);
    wait_pulse(name);
    tick();
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      fail_now("scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    chk({e.name, ".time"},    dut_time(),         e.t);
    chk({e.name, ".running"}, int'(running),      int'(e.run));
    chk({e.name, ".ended"},   int'(timer_ended),  int'(e.ended));
    chk({e.name, ".warning"}, int'(time_warning), int'(e.warn));
    chk({e.name, ".ack"},     int'(bonus_ack),    int'(e.ack));
  endtask

  // Inputs already driven: record expectation, advance, compare.
  task automatic expect_after(input string name, input int t, input logic run,
                              input logic ended, input logic warn, input logic ack,
                              input logic to_pulse);
    exp_t e;
    e.name = name; e.t = t; e.run = run; e.ended = ended; e.warn = warn; e.ack = ack;
    sb.push_back(e);
    if (to_pulse) adv_pulse(name);
    else          tick();
    sb_check();
  endtask

  task automatic apply(input vec_t v);
    load = v.ld; level_sel = v.lvl; game_on = v.go; pause = v.pz; bonus_req = v.bn;
    expect_after(v.name, v.t, v.run, v.ended, v.warn, v.ack, v.to_pulse);
  endtask

  initial begin
    //            name            ld lvl  go pz bn tp   t   run end wrn ack
    vecs[0]  = '{"idle_bonus",    0, 2'd0, 0, 0, 1, 0,   0,  0,  0,  0,  1};
    vecs[1]  = '{"lvl3_load",     1, 2'd3, 0, 0, 0, 0, 300,  0,  0,  0,  0};
    vecs[2]  = '{"armed_wait",    0, 2'd1, 0, 0, 0, 0, 300,  0,  0,  0,  0};
    vecs[3]  = '{"start",         0, 2'd1, 1, 0, 0, 0, 300,  1,  0,  0,  0};
    vecs[4]  = '{"dec_259",       0, 2'd1, 1, 0, 0, 1, 259,  1,  0,  0,  0};
    vecs[5]  = '{"dec_258",       0, 2'd1, 1, 0, 0, 1, 258,  1,  0,  0,  0};
    vecs[6]  = '{"run_to_armed",  0, 2'd1, 0, 0, 0, 0, 258,  0,  0,  0,  0};
    vecs[7]  = '{"bonus_armed",   0, 2'd1, 0, 0, 1, 0, 328,  0,  0,  0,  1};
    vecs[8]  = '{"bonus_drop",    0, 2'd1, 0, 0, 0, 0, 328,  0,  0,  0,  0};
    vecs[9]  = '{"lvl2_load",     1, 2'd2, 0, 0, 0, 0,  45,  0,  0,  0,  0};
    vecs[10] = '{"start2",        0, 2'd2, 1, 0, 0, 0,  45,  1,  0,  0,  0};
    vecs[11] = '{"pause",         0, 2'd2, 1, 1, 0, 0,  45,  0,  0,  0,  0};
    vecs[12] = '{"hold_pulse1",   0, 2'd2, 1, 1, 0, 1,  45,  0,  0,  0,  0};
    vecs[13] = '{"hold_pulse2",   0, 2'd2, 1, 1, 0, 1,  45,  0,  0,  0,  0};
    vecs[14] = '{"hold_pulse3",   0, 2'd2, 1, 1, 0, 1,  45,  0,  0,  0,  0};
    vecs[15] = '{"resume",        0, 2'd2, 1, 0, 0, 0,  45,  1,  0,  0,  0};
    vecs[16] = '{"dec_044",       0, 2'd2, 1, 0, 0, 1,  44,  1,  0,  0,  0};

    // Reset state
    repeat (3) tick();
    chk("rst.time", dut_time(), 0);
    chk("rst.running", int'(running), 0);
    chk("rst.ended", int'(timer_ended), 0);
    chk("rst.warning", int'(time_warning), 0);
    chk("rst.ack", int'(bonus_ack), 0);
    chk("rst.pulse", int'(one_sec_pulse), 0);

    // Prescaler: pulse after edges 10, 20, 30 following release, one cycle wide
    resetN = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      chk($sformatf("presc.c%0d", c), int'(one_sec_pulse), (c % 10 == 0) ? 1 : 0);
    end
    chk("presc.idle_time", dut_time(), 0);
    chk("presc.idle_running", int'(running), 0);

    foreach (vecs[i]) apply(vecs[i]);

    // Count down from 0:44 to 0:01; warning appears at 0:30
    for (int s = 43; s >= 1; s--)
      expect_after($sformatf("down_%0d", s), mmss(s), 1, 0, (s <= 30), 0, 1);

    // Bonus on the expiring tick rescues the timer: 1 - 1 + 30 = 0:30
    wait_pulse("pre_bonus_expiry");
    chk("pre_bonus_expiry.time", dut_time(), 1);
    bonus_req = 1'b1;
    expect_after("bonus_at_expiry", 30, 1, 0, 1, 1, 0);
    bonus_req = 1'b0;
    expect_after("bonus_drop2", 30, 1, 0, 1, 0, 0);

    for (int s = 29; s >= 1; s--)
      expect_after($sformatf("down2_%0d", s), mmss(s), 1, 0, 1, 0, 1);

    // Natural expiry: 0:00 and ended on the same edge, then frozen
    wait_pulse("pre_expiry");
    chk("pre_expiry.time", dut_time(), 1);
    chk("pre_expiry.ended", int'(timer_ended), 0);
    expect_after("expire", 0, 0, 1, 0, 0, 0);
    expect_after("expired_hold", 0, 0, 1, 0, 0, 1);
    load = 1'b1; level_sel = 2'd1; game_on = 1'b0;
    expect_after("reload", 300, 0, 0, 0, 0, 0);
    load = 1'b0;

    // Held bonus: grants every second cycle, then saturation at 9:59
    load = 1'b1; level_sel = 2'd2;
    expect_after("sat_load", 45, 0, 0, 0, 0, 0);
    load = 1'b0;
    bonus_req = 1'b1;
    for (int k = 1; k <= 35; k++)
      expect_after($sformatf("held_bonus_%0d", k), mmss(45 + 30 * ((k + 1) / 2)),
                   0, 0, 0, logic'(k % 2), 0);
    bonus_req = 1'b0;
    expect_after("at_945", 945, 0, 0, 0, 0, 0);
    bonus_req = 1'b1;
    expect_after("sat_959", 959, 0, 0, 0, 1, 0);
    bonus_req = 1'b0;
    expect_after("sat_hold", 959, 0, 0, 0, 0, 0);

    // Reach 1:10 in RUN, then assert reset between clock edges
    load = 1'b1;
    expect_after("rl_load", 45, 0, 0, 0, 0, 0);
    load = 1'b0; bonus_req = 1'b1;
    expect_after("rl_bonus", mmss(75), 0, 0, 0, 1, 0);
    bonus_req = 1'b0; game_on = 1'b1;
    expect_after("rl_start", mmss(75), 1, 0, 0, 0, 0);
    for (int s = 74; s >= 70; s--)
      expect_after($sformatf("rl_down_%0d", s), mmss(s), 1, 0, 0, 0, 1);
    #3;
    resetN = 1'b0;
    #1;
    chk("async_rst.time", dut_time(), 0);
    chk("async_rst.running", int'(running), 0);
    chk("async_rst.ended", int'(timer_ended), 0);
    chk("async_rst.warning", int'(time_warning), 0);
    chk("async_rst.pulse", int'(one_sec_pulse), 0);
    tick();
    tick();
    resetN = 1'b1; game_on = 1'b0;
    expect_after("post_rst_idle", 0, 0, 0, 0, 0, 0);
    load = 1'b1; level_sel = 2'd3;
    expect_after("post_rst_lvl3", 300, 0, 0, 0, 0, 0);
    load = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
